// File: rtl/canonical_code_gen.sv
// Canonical Huffman code assigner: loads per-symbol lengths, counts them, derives first codes, then streams codewords.
// Defining CHM_TABLE_CHECK_EN enables table validity checking (sticky err, ERR state).
module canonical_code_gen #(
  parameter int NUM_SYM = 10,
  parameter int MAX_LEN = 9,
  parameter int LEN_W   = 4,
  localparam int SYM_W  = $clog2(NUM_SYM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       len_valid,
  output logic                       len_ready,
  input  logic [SYM_W-1:0]           len_sym,
  input  logic [LEN_W-1:0]           len_val,
  input  logic                       len_last,
  output logic                       code_valid,
  input  logic                       code_ready,
  output logic [SYM_W-1:0]           code_sym,
  output logic [LEN_W-1:0]           code_len,
  output logic [MAX_LEN-1:0]         code_word,
  output logic                       code_last,
  output logic [NUM_SYM*MAX_LEN-1:0] code_table,
  output logic                       busy,
  output logic                       err
);

  localparam int CNT_W  = $clog2(NUM_SYM + 1);
  localparam int CODE_W = MAX_LEN + 1;
  localparam int LW     = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, NEXT, EMIT, ERR} state_t;

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           len_q [NUM_SYM];
  logic [LEN_W-1:0]           len_d [NUM_SYM];
  logic [CNT_W-1:0]           bl_count_q [MAX_LEN+1];
  logic [CNT_W-1:0]           bl_count_d [MAX_LEN+1];
  logic [CODE_W-1:0]          next_code_q [MAX_LEN+1];
  logic [CODE_W-1:0]          next_code_d [MAX_LEN+1];
  logic [CODE_W-1:0]          code_q, code_d;
  logic [SYM_W-1:0]           sym_idx_q, sym_idx_d;
  logic [LW-1:0]              bit_idx_q, bit_idx_d;
  logic                       err_q, err_d;
  logic                       code_valid_q, code_valid_d;
  logic [SYM_W-1:0]           code_sym_q, code_sym_d;
  logic [LEN_W-1:0]           code_len_q, code_len_d;
  logic [MAX_LEN-1:0]         code_word_q, code_word_d;
  logic                       code_last_q, code_last_d;
  logic [NUM_SYM*MAX_LEN-1:0] code_table_q, code_table_d;

  logic                       len_acc, len_bad, beat_load, cur_in_range;
  logic [LEN_W-1:0]           len_wr, cur_len;
  logic [LW-1:0]              cur_idx;
  logic [CNT_W-1:0]           prev_cnt;
  logic [CODE_W-1:0]          code_sum, code_new;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (len_acc) state_d = len_last ? COUNT : LOAD;
      LOAD:    if (len_acc && len_last) state_d = COUNT;
      COUNT:   if (sym_idx_q == SYM_W'(NUM_SYM - 1)) state_d = NEXT;
      NEXT:    if (bit_idx_q == LW'(MAX_LEN)) state_d = err_d ? ERR : EMIT;
      EMIT:    if (code_valid_q && code_ready && code_last_q) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_ready = (state_q == IDLE) || (state_q == LOAD);
    busy      = (state_q != IDLE);
  end

`ifdef CHM_TABLE_CHECK_EN
  assign len_wr  = len_val;
  assign len_bad = (len_val > LEN_W'(MAX_LEN));
`else
  assign len_wr  = LEN_W'(len_val[LW-1:0]);
  assign len_bad = 1'b0;
`endif

  assign len_acc      = len_valid && len_ready;
  assign cur_len      = len_q[sym_idx_q];
  assign cur_idx      = cur_len[LW-1:0];
  assign cur_in_range = (cur_len != '0) && (cur_len <= LEN_W'(MAX_LEN));
  assign prev_cnt     = (bit_idx_q == LW'(1)) ? '0 : bl_count_q[bit_idx_q - 1'b1];
  assign code_sum     = code_q + CODE_W'(prev_cnt);
  assign code_new     = {code_sum[CODE_W-2:0], 1'b0};

  always_comb begin
    len_d        = len_q;
    bl_count_d   = bl_count_q;
    next_code_d  = next_code_q;
    code_d       = code_q;
    sym_idx_d    = sym_idx_q;
    bit_idx_d    = bit_idx_q;
    err_d        = err_q;
    code_valid_d = code_valid_q;
    code_sym_d   = code_sym_q;
    code_len_d   = code_len_q;
    code_word_d  = code_word_q;
    code_last_d  = code_last_q;
    code_table_d = code_table_q;
    beat_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_acc) begin
          for (int i = 0; i < NUM_SYM; i++) len_d[i] = '0;
          for (int b = 0; b <= MAX_LEN; b++) bl_count_d[b] = '0;
          code_table_d = '0;
          err_d        = len_bad;
          sym_idx_d    = '0;
          if (int'(len_sym) < NUM_SYM) len_d[len_sym] = len_wr;
        end
      end
      LOAD: begin
        if (len_acc) begin
          if (int'(len_sym) < NUM_SYM) len_d[len_sym] = len_wr;
          if (len_bad) err_d = 1'b1;
        end
      end
      COUNT: begin
        if (cur_in_range) bl_count_d[cur_idx] = bl_count_q[cur_idx] + 1'b1;
        sym_idx_d = (sym_idx_q == SYM_W'(NUM_SYM - 1)) ? '0 : sym_idx_q + 1'b1;
        bit_idx_d = LW'(1);
        code_d    = '0;
      end
      NEXT: begin
        next_code_d[bit_idx_q] = code_new;
        code_d                 = code_new;
        bit_idx_d              = bit_idx_q + 1'b1;
        sym_idx_d              = '0;
`ifdef CHM_TABLE_CHECK_EN
        // Oversubscription: the codes of this length would run past 2^bits
        if ((32'(code_new) + 32'(bl_count_q[bit_idx_q])) > (32'd1 << bit_idx_q)) err_d = 1'b1;
`endif
      end
      EMIT: begin
        if (!code_valid_q) begin
          beat_load = 1'b1;
        end else if (code_ready) begin
          code_table_d[int'(code_sym_q)*MAX_LEN +: MAX_LEN] = code_word_q;
          code_valid_d = 1'b0;
          beat_load    = !code_last_q;
        end
      end
      default: ;
    endcase

    // Loading the next beat on the handshake edge keeps the stream back-to-back
    if (beat_load) begin
      code_valid_d = 1'b1;
      code_sym_d   = sym_idx_q;
      code_len_d   = cur_len;
      code_last_d  = (sym_idx_q == SYM_W'(NUM_SYM - 1));
      code_word_d  = '0;
      sym_idx_d    = sym_idx_q + 1'b1;
      if (cur_in_range) begin
        code_word_d          = next_code_q[cur_idx][MAX_LEN-1:0];
        next_code_d[cur_idx] = next_code_q[cur_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYM; i++) len_q[i] <= '0;
      for (int b = 0; b <= MAX_LEN; b++) begin
        bl_count_q[b]  <= '0;
        next_code_q[b] <= '0;
      end
      code_q       <= '0;
      sym_idx_q    <= '0;
      bit_idx_q    <= '0;
      err_q        <= 1'b0;
      code_valid_q <= 1'b0;
      code_sym_q   <= '0;
      code_len_q   <= '0;
      code_word_q  <= '0;
      code_last_q  <= 1'b0;
      code_table_q <= '0;
    end else begin
      len_q        <= len_d;
      bl_count_q   <= bl_count_d;
      next_code_q  <= next_code_d;
      code_q       <= code_d;
      sym_idx_q    <= sym_idx_d;
      bit_idx_q    <= bit_idx_d;
      err_q        <= err_d;
      code_valid_q <= code_valid_d;
      code_sym_q   <= code_sym_d;
      code_len_q   <= code_len_d;
      code_word_q  <= code_word_d;
      code_last_q  <= code_last_d;
      code_table_q <= code_table_d;
    end
  end

  assign code_valid = code_valid_q;
  assign code_sym   = code_sym_q;
  assign code_len   = code_len_q;
  assign code_word  = code_word_q;
  assign code_last  = code_last_q;
  assign code_table = code_table_q;
  assign err        = err_q;

endmodule

// File: tb/tb_canonical_code_gen.sv
// Randomized self-checking bench for canonical_code_gen (NUM_SYM=4, MAX_LEN=3),
// compared against a Kraft-sum / sorted-assignment reference model.
module tb_canonical_code_gen;

  localparam int NUM_SYM = 4;
  localparam int MAX_LEN = 3;
  localparam int LEN_W   = 4;
  localparam int SYM_W   = $clog2(NUM_SYM);
  localparam int TRUNC_W = $clog2(MAX_LEN + 1);
`ifdef CHM_TABLE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       len_valid;
  logic                       len_ready;
  logic [SYM_W-1:0]           len_sym;
  logic [LEN_W-1:0]           len_val;
  logic                       len_last;
  logic                       code_valid;
  logic                       code_ready;
  logic [SYM_W-1:0]           code_sym;
  logic [LEN_W-1:0]           code_len;
  logic [MAX_LEN-1:0]         code_word;
  logic                       code_last;
  logic [NUM_SYM*MAX_LEN-1:0] code_table;
  logic                       busy;
  logic                       err;

  canonical_code_gen #(.NUM_SYM(NUM_SYM), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .len_valid(len_valid), .len_ready(len_ready), .len_sym(len_sym),
    .len_val(len_val), .len_last(len_last),
    .code_valid(code_valid), .code_ready(code_ready), .code_sym(code_sym),
    .code_len(code_len), .code_word(code_word), .code_last(code_last),
    .code_table(code_table), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;
  int curLens [NUM_SYM];
  int expLen  [NUM_SYM];
  int expWord [NUM_SYM];
  bit expErr;
  bit wordsKnown;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: codes of each length are handed out in symbol order, then the counter doubles
  function automatic void computeModel();
    int kraft = 0;
    int code = 0;
    bit tooLong = 1'b0;
    for (int s = 0; s < NUM_SYM; s++) begin
      expLen[s]  = CHECK_EN ? curLens[s] : (curLens[s] % (1 << TRUNC_W));
      expWord[s] = 0;
      if (expLen[s] > MAX_LEN) tooLong = 1'b1;
      else if (expLen[s] > 0) kraft += 1 << (MAX_LEN - expLen[s]);
    end
    wordsKnown = !tooLong && (kraft <= (1 << MAX_LEN));
    expErr     = CHECK_EN && !wordsKnown;
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        if (expLen[s] == l) begin
          expWord[s] = code;
          code++;
        end
      end
      code = code * 2;
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".len_ready"}, len_ready, 1);
    checkOutput({tag, ".code_valid"}, code_valid, 0);
    checkOutput({tag, ".code_sym"}, code_sym, 0);
    checkOutput({tag, ".code_len"}, code_len, 0);
    checkOutput({tag, ".code_word"}, code_word, 0);
    checkOutput({tag, ".code_last"}, code_last, 0);
    checkOutput({tag, ".code_table"}, code_table, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".err"}, err, 0);
  endtask

  task automatic sendLoad(input bit withDup);
    int order [NUM_SYM];
    int bSym [NUM_SYM+1];
    int bVal [NUM_SYM+1];
    int nBeats = 0;
    for (int s = 0; s < NUM_SYM; s++) order[s] = s;
    for (int s = NUM_SYM - 1; s > 0; s--) begin
      int j = $urandom_range(0, s);
      int t = order[s];
      order[s] = order[j];
      order[j] = t;
    end
    if (withDup) begin
      bSym[0] = order[$urandom_range(0, NUM_SYM - 1)];
      bVal[0] = $urandom_range(1, MAX_LEN);
      nBeats  = 1;
    end
    for (int s = 0; s < NUM_SYM; s++) begin
      bSym[nBeats] = order[s];
      bVal[nBeats] = curLens[order[s]];
      nBeats++;
    end
    for (int i = 0; i < nBeats; i++) begin
      checkOutput("lenReadyLoad", len_ready, 1);
      len_valid = 1'b1;
      len_sym   = SYM_W'(bSym[i]);
      len_val   = LEN_W'(bVal[i]);
      len_last  = (i == nBeats - 1);
      @(negedge clk);
      if (i == 0) checkOutput("errAtAccept", err, CHECK_EN && (bVal[0] > MAX_LEN));
      if (i < nBeats - 1 && $urandom_range(0, 3) == 0) begin
        len_valid = 1'b0;
        @(negedge clk);
      end
    end
    len_valid = 1'b0;
    len_last  = 1'b0;
  endtask

  task automatic waitAndEmit(input int mode);
    int cyc = 0;
    int beat = 0;
    int guard = 0;
    int valids = 0;
    int rcount = 0;
    bit rdy;
    if (expErr) begin
      for (int c = 0; c < NUM_SYM + MAX_LEN + 3; c++) begin
        @(negedge clk);
        if (code_valid) valids++;
      end
      checkOutput("noEmitOnErr", valids, 0);
      checkOutput("errSticky", err, 1);
      checkOutput("busyAfterErr", busy, 0);
      return;
    end
    while (!code_valid && cyc < 100) begin
      len_valid = 1'($urandom_range(0, 1));
      len_sym   = SYM_W'($urandom);
      len_val   = LEN_W'($urandom);
      len_last  = 1'($urandom_range(0, 1));
      code_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        checkOutput("lenReadyBusy", len_ready, 0);
        checkOutput("busyCount", busy, 1);
      end
    end
    len_valid = 1'b0;
    len_last  = 1'b0;
    checkOutput("firstValidLatency", cyc, NUM_SYM + MAX_LEN + 1);
    while (beat < NUM_SYM && guard < 200) begin
      checkOutput("validHeld", code_valid, 1);
      if (!code_valid) break;
      checkOutput("sym", code_sym, beat);
      checkOutput("len", code_len, expLen[beat]);
      if (wordsKnown) checkOutput("word", code_word, expWord[beat]);
      checkOutput("last", code_last, beat == NUM_SYM - 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (rcount % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rcount++;
      code_ready = rdy;
      @(negedge clk);
      guard++;
      if (rdy) begin
        if (wordsKnown) checkOutput("tableSlice", code_table[beat*MAX_LEN +: MAX_LEN], expWord[beat]);
        beat++;
      end
    end
    code_ready = 1'b0;
    checkOutput("beatCount", beat, NUM_SYM);
    checkOutput("validAfterLast", code_valid, 0);
    checkOutput("busyAfterLast", busy, 0);
    checkOutput("errClear", err, 0);
    if (wordsKnown)
      for (int s = 0; s < NUM_SYM; s++)
        checkOutput("table", code_table[s*MAX_LEN +: MAX_LEN], expWord[s]);
  endtask

  task automatic applyStimulus(input int lens [NUM_SYM], input int mode, input bit withDup);
    curLens = lens;
    computeModel();
    sendLoad(withDup);
    waitAndEmit(mode);
    @(negedge clk);
  endtask

  task automatic midEmitReset();
    int cyc = 0;
    curLens = '{2, 1, 3, 3};
    computeModel();
    sendLoad(1'b0);
    while (!code_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midFirstValid", code_valid, 1);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    checkOutput("midSecondSym", code_sym, 1);
    reset = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rl [NUM_SYM];
    reset      = 1'b0;
    len_valid  = 1'b0;
    len_sym    = '0;
    len_val    = '0;
    len_last   = 1'b0;
    code_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;
    @(negedge clk);

    applyStimulus('{2, 1, 3, 3}, 0, 1'b0);
    applyStimulus('{2, 1, 3, 3}, 1, 1'b0);
    applyStimulus('{1, 0, 2, 2}, 2, 1'b0);
    applyStimulus('{1, 1, 1, 0}, 0, 1'b0);
    applyStimulus('{1, 12, 2, 2}, 0, 1'b0);
    applyStimulus('{2, 1, 3, 3}, 0, 1'b1);
    midEmitReset();
    applyStimulus('{2, 1, 3, 3}, 2, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        rl[s] = $urandom_range(0, MAX_LEN);
        if ($urandom_range(0, 9) == 0) rl[s] = $urandom_range(MAX_LEN + 1, 15);
      end
      applyStimulus(rl, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
